ufir_cuad_sched: RTL and testbench

Scheduler for the time-multiplexed quadratic UFIR filter datapath. Two sample channels (the `dpi_1` / `dpi_2` streams of the golden model) share one coefficient ROM, one dual-bank sample buffer and one pipelined multiply-accumulate unit. The block arbitrates between channels and generates buffer write/read addresses, coefficient addresses and MAC control. It flags when each channel's filtered output is valid in the accumulator. It sits between the sample source and the shared MAC, and it replaces the fixed overclocking counter used in the reference model harness.

---
 rtl/ufir_cuad_sched.sv | 189 ++++++++++++++++++
 tb/tb_ufir_cuad_sched.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufir_cuad_sched.sv
// ufir_cuad_sched
//
// Scheduler for the time-multiplexed quadratic UFIR datapath. Two sample
// channels share one coefficient ROM, one dual-bank sample buffer (one bank
// per channel) and one pipelined MAC. The block:
//   - arbitrates sample requests between the channels (round-robin on a
//     collision, immediate grant for a single requester),
//   - produces buffer write strobes/addresses for accepted samples,
//   - once a channel's buffer is full, runs N_HORIZON MAC taps reading the
//     newest sample first, waits MAC_LAT cycles for the pipeline to settle,
//     then pulses y_valid for that channel.
//
// Parameters
//   N_HORIZON  taps per output (power of two, >= 4)
//   ADDR_W     log2(N_HORIZON)
//   MAC_LAT    cycles from the last mac_en until the accumulator is stable (>= 1)
//
// Ports
//   clk_i           clock, all logic on its rising edge
//   reset_i         synchronous active-high reset
//   clk_enable_i    advance qualifier; 0 freezes all state and zeroes strobes
//   s_valid_i[1:0]  per-channel sample request
//   s_ready_o[1:0]  per-channel accept (one-hot or zero)
//   buf_wr_en_o     buffer write strobe
//   buf_wr_ch_o     buffer bank to write
//   buf_wr_addr_o   buffer write address
//   buf_rd_ch_o     buffer bank to read
//   buf_rd_addr_o   buffer read address
//   coef_addr_o     coefficient ROM address (tap index)
//   mac_clr_o       first tap: load accumulator with the product
//   mac_en_o        MAC step valid
//   mac_last_o      last tap of the current output
//   y_valid_o[1:0]  one-cycle pulse: accumulator holds channel c's output
//   busy_o          FSM is not idle

module ufir_cuad_sched #(
  parameter int unsigned N_HORIZON = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MAC_LAT   = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_enable_i,
  input  logic [1:0]        s_valid_i,
  output logic [1:0]        s_ready_o,
  output logic              buf_wr_en_o,
  output logic              buf_wr_ch_o,
  output logic [ADDR_W-1:0] buf_wr_addr_o,
  output logic              buf_rd_ch_o,
  output logic [ADDR_W-1:0] buf_rd_addr_o,
  output logic [ADDR_W-1:0] coef_addr_o,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic              mac_last_o,
  output logic [1:0]        y_valid_o,
  output logic              busy_o
);

  // Fill counter needs one extra bit to hold the saturated value N_HORIZON.
  localparam int unsigned FillW  = ADDR_W + 1;
  localparam int unsigned DrainW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [FillW-1:0]  FillFull  = FillW'(N_HORIZON);
  localparam logic [ADDR_W-1:0] LastTap   = ADDR_W'(N_HORIZON - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(MAC_LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDrain,
    StDone
  } state_e;

  state_e                       state_q;
  logic                         ch_q;     // channel owning the current MAC run
  logic [ADDR_W-1:0]            k_q;      // tap counter
  logic [ADDR_W-1:0]            w_q;      // address of the sample that started the run
  logic [DrainW-1:0]            drain_q;
  logic [1:0][ADDR_W-1:0]       wp_q;
  logic [1:0][FillW-1:0]        fill_q;
  logic                         rr_q;

  logic                         adv;
  logic                         both_req;
  logic                         grant_ch;
  logic                         accept;
  logic [FillW-1:0]             fill_inc;

  // Arbitration and accept decode. Reset suppresses accepts so that a sample
  // presented during reset is not reported as taken.
  always_comb begin
    adv      = clk_enable_i & ~reset_i;
    both_req = &s_valid_i;
    grant_ch = both_req ? rr_q : s_valid_i[1];
    accept   = adv && (state_q == StIdle) && (|s_valid_i);
    fill_inc = (fill_q[grant_ch] == FillFull) ? FillFull : fill_q[grant_ch] + 1'b1;
  end

  // Output decode from the registered state; every strobe and address is
  // zero unless the corresponding operation is happening this cycle.
  always_comb begin
    s_ready_o     = 2'b00;
    buf_wr_en_o   = 1'b0;
    buf_wr_ch_o   = 1'b0;
    buf_wr_addr_o = '0;
    buf_rd_ch_o   = 1'b0;
    buf_rd_addr_o = '0;
    coef_addr_o   = '0;
    mac_clr_o     = 1'b0;
    mac_en_o      = 1'b0;
    mac_last_o    = 1'b0;
    y_valid_o     = 2'b00;
    busy_o        = (state_q != StIdle);

    if (accept) begin
      s_ready_o[grant_ch] = 1'b1;
      buf_wr_en_o         = 1'b1;
      buf_wr_ch_o         = grant_ch;
      buf_wr_addr_o       = wp_q[grant_ch];
    end

    if (adv && (state_q == StMac)) begin
      mac_en_o      = 1'b1;
      coef_addr_o   = k_q;
      buf_rd_ch_o   = ch_q;
      // Newest sample first; modulo wrap comes from the ADDR_W-bit subtraction.
      buf_rd_addr_o = w_q - k_q;
      mac_clr_o     = (k_q == '0);
      mac_last_o    = (k_q == LastTap);
    end

    if (adv && (state_q == StDone)) begin
      y_valid_o[ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ch_q    <= 1'b0;
      k_q     <= '0;
      w_q     <= '0;
      drain_q <= '0;
      wp_q    <= '0;
      fill_q  <= '0;
      rr_q    <= 1'b0;
    end else if (clk_enable_i) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wp_q[grant_ch]   <= wp_q[grant_ch] + 1'b1;
            fill_q[grant_ch] <= fill_inc;
            // Only a real collision moves the round-robin pointer.
            if (both_req) begin
              rr_q <= ~rr_q;
            end
            if (fill_inc == FillFull) begin
              state_q <= StMac;
              ch_q    <= grant_ch;
              w_q     <= wp_q[grant_ch];
              k_q     <= '0;
            end
          end
        end
        StMac: begin
          k_q <= k_q + 1'b1;
          if (k_q == LastTap) begin
            state_q <= StDrain;
            drain_q <= '0;
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ufir_cuad_sched.sv
// Self-checking bench for ufir_cuad_sched. A schedule-based reference model
// turns every accepted sample into a timeline of expected MAC taps and
// y_valid pulses, indexed by "enabled cycle" time, and each scenario task
// compares the full output vector every cycle plus scenario-specific timing.

module tb_ufir_cuad_sched;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic [1:0]    s_valid;
  logic [1:0]    s_ready;
  logic          buf_wr_en;
  logic          buf_wr_ch;
  logic [AW-1:0] buf_wr_addr;
  logic          buf_rd_ch;
  logic [AW-1:0] buf_rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          mac_last;
  logic [1:0]    y_valid;
  logic          busy;

  always #5 clk = ~clk;

  ufir_cuad_sched #(
    .N_HORIZON(N),
    .ADDR_W   (AW),
    .MAC_LAT  (L)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .clk_enable_i (clk_enable),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .buf_wr_en_o  (buf_wr_en),
    .buf_wr_ch_o  (buf_wr_ch),
    .buf_wr_addr_o(buf_wr_addr),
    .buf_rd_ch_o  (buf_rd_ch),
    .buf_rd_addr_o(buf_rd_addr),
    .coef_addr_o  (coef_addr),
    .mac_clr_o    (mac_clr),
    .mac_en_o     (mac_en),
    .mac_last_o   (mac_last),
    .y_valid_o    (y_valid),
    .busy_o       (busy)
  );

  typedef struct packed {
    logic [1:0]    s_ready;
    logic          wr_en;
    logic          wr_ch;
    logic [AW-1:0] wr_addr;
    logic          rd_ch;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] coef;
    logic          clr;
    logic          mac_en;
    logic          last;
    logic [1:0]    y_valid;
    logic          busy;
  } outs_t;

  typedef struct {
    int ch;
    int addr;
    int k;
  } mac_t;

  outs_t obs;
  outs_t exp_o;
  int    checks = 0;
  int    passes = 0;
  int    cyc    = 0;
  int    obs_cyc;

  // Reference model state (time counts enabled, non-reset cycles only).
  int    now     = 0;
  int    free_at = 0;
  int    fill[2];
  int    wp[2];
  int    rr;
  mac_t  mac_ev[int];
  int    y_ev[int];

  function automatic outs_t model_expect(input logic [1:0] sv, input logic en,
                                         input logic rst);
    outs_t e;
    int    g;
    mac_t  m;
    e = '0;
    e.busy = (now < free_at);
    if (rst || !en) return e;
    if (now >= free_at && sv != 2'b00) begin
      g = (sv == 2'b11) ? rr : (sv[1] ? 1 : 0);
      e.s_ready[g] = 1'b1;
      e.wr_en      = 1'b1;
      e.wr_ch      = g[0];
      e.wr_addr    = AW'(wp[g]);
    end
    if (mac_ev.exists(now)) begin
      m = mac_ev[now];
      e.mac_en  = 1'b1;
      e.rd_ch   = m.ch[0];
      e.rd_addr = AW'(m.addr);
      e.coef    = AW'(m.k);
      e.clr     = (m.k == 0);
      e.last    = (m.k == N - 1);
    end
    if (y_ev.exists(now)) e.y_valid[y_ev[now]] = 1'b1;
    return e;
  endfunction

  function automatic void model_update(input logic [1:0] sv, input logic en,
                                       input logic rst);
    int g;
    int w;
    if (rst) begin
      fill = '{0, 0};
      wp   = '{0, 0};
      rr   = 0;
      now++;
      free_at = now;
      mac_ev.delete();
      y_ev.delete();
      return;
    end
    if (!en) return;
    if (now >= free_at && sv != 2'b00) begin
      g = (sv == 2'b11) ? rr : (sv[1] ? 1 : 0);
      w = wp[g];
      wp[g] = (wp[g] + 1) % N;
      if (fill[g] < N) fill[g]++;
      if (sv == 2'b11) rr = 1 - rr;
      if (fill[g] == N) begin
        for (int i = 0; i < N; i++) mac_ev[now + 1 + i] = '{g, (w - i + N) % N, i};
        y_ev[now + N + L + 1] = g;
        free_at = now + N + L + 2;
      end
    end
    now++;
  endfunction

  task automatic drive_cycle(input logic [1:0] sv, input logic en, input logic rst);
    s_valid    = sv;
    clk_enable = en;
    reset      = rst;
    @(negedge clk);
    obs.s_ready = s_ready;
    obs.wr_en   = buf_wr_en;
    obs.wr_ch   = buf_wr_ch;
    obs.wr_addr = buf_wr_addr;
    obs.rd_ch   = buf_rd_ch;
    obs.rd_addr = buf_rd_addr;
    obs.coef    = coef_addr;
    obs.clr     = mac_clr;
    obs.mac_en  = mac_en;
    obs.last    = mac_last;
    obs.y_valid = y_valid;
    obs.busy    = busy;
    exp_o       = model_expect(sv, en, rst);
    obs_cyc     = cyc;
    @(posedge clk);
    #1;
    model_update(sv, en, rst);
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_cycle(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== outs_t'(0)) $display("FAIL reset_outs cyc=%0d got=%h exp=0", obs_cyc, obs);
      else passes++;
    end
  endtask

  task automatic test_fill_ch0();
    int acc = 0, dacc = 0, first = -1, t16 = -1, ycyc = -1, nmac = 0;
    for (int i = 0; i < 45; i++) begin
      drive_cycle((acc < 16) ? 2'b01 : 2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL fill cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready[0]) acc++;
      if (obs.s_ready === 2'b01) begin
        dacc++;
        if (dacc == 1) first = obs_cyc;
        if (dacc == 16) t16 = obs_cyc;
      end
      if (obs.mac_en === 1'b1) begin
        checks++;
        if (obs.rd_addr !== AW'(15 - nmac) || obs.coef !== AW'(nmac) ||
            obs.clr !== (nmac == 0) || obs.last !== (nmac == 15) || obs_cyc != t16 + 1 + nmac)
          $display("FAIL fill_tap n=%0d got rd=%0d coef=%0d cyc=%0d exp rd=%0d coef=%0d cyc=%0d",
                   nmac, obs.rd_addr, obs.coef, obs_cyc, 15 - nmac, nmac, t16 + 1 + nmac);
        else passes++;
        nmac++;
      end
      if (obs.y_valid === 2'b01) ycyc = obs_cyc;
    end
    checks++;
    if (t16 - first != 15) $display("FAIL fill_b2b got=%0d exp=15", t16 - first);
    else passes++;
    checks++;
    if (nmac != 16) $display("FAIL fill_ntaps got=%0d exp=16", nmac);
    else passes++;
    checks++;
    if (ycyc - t16 != 19) $display("FAIL fill_yvalid got=%0d exp=19", ycyc - t16);
    else passes++;
  endtask

  task automatic test_wrap();
    int acc = 0, nmac = 0, ny = 0;
    for (int i = 0; i < 25; i++) begin
      drive_cycle((acc < 1) ? 2'b01 : 2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL wrap cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready[0]) begin
        acc++;
        checks++;
        if (obs.wr_addr !== AW'(0)) $display("FAIL wrap_wr got=%0d exp=0", obs.wr_addr);
        else passes++;
      end
      if (obs.mac_en === 1'b1) begin
        checks++;
        if (obs.rd_addr !== AW'((16 - nmac) % 16))
          $display("FAIL wrap_rd n=%0d got=%0d exp=%0d", nmac, obs.rd_addr, (16 - nmac) % 16);
        else passes++;
        nmac++;
      end
      if (obs.y_valid === 2'b01) ny++;
    end
    checks++;
    if (nmac != 16 || ny != 1) $display("FAIL wrap_count got=%0d/%0d exp=16/1", nmac, ny);
    else passes++;
  endtask

  task automatic test_alternate();
    int acc = 0, grants = 0, both_rdy = 0;
    int gcyc[$], gch[$], ys[$];
    while (acc < 16 && acc >= 0) begin
      drive_cycle(2'b10, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL alt_fill cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready[1]) acc++;
      if (obs_cyc > 200) acc = -1;
    end
    for (int i = 0; i < 90; i++) begin
      drive_cycle((grants < 3) ? 2'b11 : 2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL alt cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready != 2'b00) grants++;
      if (obs.s_ready === 2'b11) both_rdy++;
      if (obs.s_ready === 2'b01 || obs.s_ready === 2'b10) begin
        gcyc.push_back(obs_cyc);
        gch.push_back(obs.s_ready[1] ? 1 : 0);
      end
      if (obs.y_valid !== 2'b00) ys.push_back(int'(obs.y_valid));
    end
    checks++;
    if (both_rdy != 0) $display("FAIL alt_ready11 got=%0d cycles exp=0", both_rdy);
    else passes++;
    checks++;
    if (gch.size() != 3 || gch[0] != 0 || gch[1] != 1 || gch[2] != 0)
      $display("FAIL alt_order got=%0d grants exp=3 grants ch0,ch1,ch0", gch.size());
    else passes++;
    checks++;
    if (gcyc.size() != 3 || gcyc[1] - gcyc[0] != 20 || gcyc[2] - gcyc[1] != 20)
      $display("FAIL alt_spacing got=%0d grants exp=3 spaced 20", gcyc.size());
    else passes++;
    checks++;
    if (ys.size() != 4 || ys[0] != 2 || ys[1] != 1 || ys[2] != 2 || ys[3] != 1)
      $display("FAIL alt_yvalid got=%0d pulses exp=10,01,10,01", ys.size());
    else passes++;
  endtask

  task automatic test_single_req();
    int ph = 0;
    int gcyc[$], gch[$];
    for (int i = 0; i < 85; i++) begin
      drive_cycle((ph == 0) ? 2'b10 : (ph == 1) ? 2'b01 : (ph == 2) ? 2'b11 : 2'b00,
                  1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL single cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready != 2'b00) ph++;
      if (obs.s_ready === 2'b01 || obs.s_ready === 2'b10) begin
        gcyc.push_back(obs_cyc);
        gch.push_back(obs.s_ready[1] ? 1 : 0);
      end
    end
    checks++;
    if (gch.size() != 3 || gch[0] != 1 || gch[1] != 0 || gch[2] != 1)
      $display("FAIL single_order got=%0d grants exp=3 grants ch1,ch0,ch1", gch.size());
    else passes++;
    checks++;
    if (gcyc.size() != 3 || gcyc[1] - gcyc[0] != 20)
      $display("FAIL single_immediate got=%0d grants exp=ch0 20 after ch1", gcyc.size());
    else passes++;
  endtask

  task automatic test_clk_gate();
    int t = -1, ycyc = -1, gap_bad = 0;
    for (int i = 0; i < 10 && t < 0; i++) begin
      drive_cycle(2'b01, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL gate_acc cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready[0]) t = obs_cyc;
    end
    for (int j = 1; j <= 30; j++) begin
      drive_cycle(2'b00, (j >= 6 && j <= 8) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL gate cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (j >= 6 && j <= 8 && (obs.mac_en !== 1'b0 || obs.busy !== 1'b1)) gap_bad++;
      if (j == 9) begin
        checks++;
        if (obs.mac_en !== 1'b1 || obs.coef !== AW'(5))
          $display("FAIL gate_resume got en=%b coef=%0d exp en=1 coef=5", obs.mac_en, obs.coef);
        else passes++;
      end
      if (obs.y_valid === 2'b01) ycyc = obs_cyc;
    end
    checks++;
    if (gap_bad != 0) $display("FAIL gate_gap got=%0d bad cycles exp=0", gap_bad);
    else passes++;
    checks++;
    if (ycyc - t != 22) $display("FAIL gate_yvalid got=%0d exp=22", ycyc - t);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int t = -1, ny = 0, ntap = 0, acc = 0, dacc = 0, acc_at_mac = -1;
    for (int i = 0; i < 10 && t < 0; i++) begin
      drive_cycle(2'b01, 1'b1, 1'b0);
      if (exp_o.s_ready[0]) t = obs_cyc;
    end
    for (int j = 1; j <= 30; j++) begin
      drive_cycle(2'b00, 1'b1, (j == 6) ? 1'b1 : 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL rstmid cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (j <= 5 && obs.mac_en === 1'b1) ntap++;
      if (j == 7) begin
        checks++;
        if (obs !== outs_t'(0)) $display("FAIL rstmid_zero got=%h exp=0", obs);
        else passes++;
      end
      if (obs.y_valid !== 2'b00) ny++;
    end
    checks++;
    if (ntap != 5 || ny != 0) $display("FAIL rstmid_abandon got taps=%0d y=%0d exp 5/0", ntap, ny);
    else passes++;
    for (int i = 0; i < 45; i++) begin
      drive_cycle((acc < 16) ? 2'b01 : 2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) $display("FAIL refill cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (exp_o.s_ready[0]) acc++;
      if (obs.s_ready === 2'b01) dacc++;
      if (obs.mac_en === 1'b1 && acc_at_mac < 0) acc_at_mac = dacc;
    end
    checks++;
    if (acc_at_mac != 16) $display("FAIL refill_count got=%0d exp=16", acc_at_mac);
    else passes++;
  endtask

  task automatic test_random();
    logic [1:0] req = 2'b00;
    logic       en, rst;
    int         both_rdy = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) if (!req[c] && $urandom_range(0, 2) == 0) req[c] = 1'b1;
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      drive_cycle(req, en, rst);
      checks++;
      if (obs !== exp_o) $display("FAIL random cyc=%0d got=%h exp=%h", obs_cyc, obs, exp_o);
      else passes++;
      if (obs.s_ready === 2'b11) both_rdy++;
      req = req & ~exp_o.s_ready;
    end
    checks++;
    if (both_rdy != 0) $display("FAIL random_ready11 got=%0d exp=0", both_rdy);
    else passes++;
  endtask

  initial begin
    s_valid    = 2'b00;
    clk_enable = 1'b1;
    reset      = 1'b1;
    fill = '{0, 0};
    wp   = '{0, 0};
    rr   = 0;
    test_reset();
    test_fill_ch0();
    test_wrap();
    test_alternate();
    test_single_req();
    test_clk_gate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
